// File: rtl/seg_pkg.sv
// Shared 7-segment display definitions: scheduler state encoding and the blank glyph.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2,
    ST_GAP  = 2'd3
  } seg_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_char_fifo.sv
// Synchronous character FIFO; head is read combinationally, occupancy is a registered count.
module seg_char_fifo #(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [CHAR_W-1:0]        i_data,
  output logic [CHAR_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == {(AW+1){1'b0}});

endmodule

// File: rtl/seg_char_scheduler.sv
// Buffers host characters and feeds them one at a time to the 7-seg animator, paced by frame ticks.
// Optional blank gap between characters: define SEG_SCHED_GAP_EN.
module seg_char_scheduler
  import seg_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CHAR_W    = 7,
  parameter int DWELL_W   = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   frame_tick,
  input  logic                   wr_valid,
  input  logic [CHAR_W-1:0]      wr_char,
  output logic                   wr_ready,
  input  logic [DWELL_W-1:0]     dwell,
  output logic                   anim_strobe,
  output logic [CHAR_W-1:0]      anim_char,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  seg_state_e          r_state;
  seg_state_e          w_state_nxt;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic [DWELL_W-1:0]  w_dwell_nxt;
  logic                r_strobe;
  logic                w_strobe_nxt;
  logic [CHAR_W-1:0]   r_char;
  logic [CHAR_W-1:0]   w_char_nxt;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [CHAR_W-1:0]   w_head;

  assign w_push = wr_valid && !w_full;

  seg_char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (wr_char),
    .o_head  (w_head),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // With ena low every branch is skipped, so state, count and strobe all hold/idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell_cnt;
    w_strobe_nxt = 1'b0;
    w_char_nxt   = r_char;
    w_pop        = 1'b0;
    if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) w_state_nxt = ST_LOAD;
          else          w_state_nxt = ST_IDLE;
        end
        ST_LOAD: begin
          w_pop        = 1'b1;
          w_char_nxt   = w_head;
          w_strobe_nxt = 1'b1;
          w_dwell_nxt  = (dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : dwell;
          w_state_nxt  = ST_SHOW;
        end
        ST_SHOW: begin
          if (frame_tick) begin
            w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
            if (r_dwell_cnt <= DWELL_W'(1)) begin
`ifdef SEG_SCHED_GAP_EN
              w_state_nxt  = ST_GAP;
              w_char_nxt   = CHAR_W'(SEG_BLANK);
              w_strobe_nxt = 1'b1;
              w_dwell_nxt  = DWELL_W'(GAP_TICKS);
`else
              w_state_nxt  = ST_IDLE;
              w_dwell_nxt  = {DWELL_W{1'b0}};
`endif
            end else begin
              w_state_nxt = ST_SHOW;
            end
          end else begin
            w_state_nxt = ST_SHOW;
          end
        end
        ST_GAP: begin
          if (frame_tick) begin
            w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
            if (r_dwell_cnt <= DWELL_W'(1)) begin
              w_state_nxt = ST_IDLE;
              w_dwell_nxt = {DWELL_W{1'b0}};
            end else begin
              w_state_nxt = ST_GAP;
            end
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_dwell_nxt = {DWELL_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dwell_cnt <= {DWELL_W{1'b0}};
      r_strobe    <= 1'b0;
      r_char      <= {CHAR_W{1'b0}};
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_strobe    <= w_strobe_nxt;
      r_char      <= w_char_nxt;
      if (wr_valid && w_full) r_overflow <= 1'b1;
    end
  end

  assign wr_ready    = !w_full;
  assign anim_strobe = r_strobe;
  assign anim_char   = r_char;
  assign busy        = (r_state != ST_IDLE);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seg_char_scheduler.sv
// Directed self-checking bench for seg_char_scheduler (default and SEG_SCHED_GAP_EN builds).
module tb_seg_char_scheduler;

  localparam int DEPTH   = 8;
  localparam int CHAR_W  = 7;
  localparam int DWELL_W = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              frame_tick;
  logic              wr_valid;
  logic [CHAR_W-1:0] wr_char;
  logic              wr_ready;
  logic [DWELL_W-1:0] dwell;
  logic              anim_strobe;
  logic [CHAR_W-1:0] anim_char;
  logic              busy;
  logic [LW-1:0]     level;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  seg_char_scheduler #(
    .DEPTH     (DEPTH),
    .CHAR_W    (CHAR_W),
    .DWELL_W   (DWELL_W),
    .GAP_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .frame_tick  (frame_tick),
    .wr_valid    (wr_valid),
    .wr_char     (wr_char),
    .wr_ready    (wr_ready),
    .dwell       (dwell),
    .anim_strobe (anim_strobe),
    .anim_char   (anim_char),
    .busy        (busy),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CHAR_W-1:0] ch);
    wr_valid = 1'b1;
    wr_char  = ch;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Waits (bounded) for a strobe, then checks the character it carries.
  task automatic expect_strobe(input string tag, input logic [CHAR_W-1:0] ch);
    int waited = 0;
    while (!anim_strobe && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_seen"}, 32'(anim_strobe), 32'd1);
    chk({tag, "_char"}, 32'(anim_char), 32'(ch));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; frame_tick = 1'b0;
    wr_valid = 1'b1; wr_char = 7'h55; dwell = 4'd3;

    // 1. Reset with wr_valid held high
    step(); step();
    chk("rst_strobe",   32'(anim_strobe), 32'd0);
    chk("rst_char",     32'(anim_char),   32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_level",    32'(level),       32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_ready",    32'(wr_ready),    32'd1);
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("rst_no_push", 32'(level), 32'd0);

    // 2. Single character, dwell 3: strobe on the third edge after the write
    push(7'h41);
    chk("s_level1", 32'(level), 32'd1);
    chk("s_idle",   32'(busy),  32'd0);
    step();
    chk("s_load_busy",   32'(busy),        32'd1);
    chk("s_load_nostrb", 32'(anim_strobe), 32'd0);
    step();
    chk("s_strobe", 32'(anim_strobe), 32'd1);
    chk("s_char",   32'(anim_char),   32'h41);
    chk("s_level0", 32'(level),       32'd0);
    step();
    chk("s_strobe_pulse", 32'(anim_strobe), 32'd0);
    tick(); chk("s_busy_t1", 32'(busy), 32'd1);
    step(); chk("s_busy_gap", 32'(busy), 32'd1);
    tick(); chk("s_busy_t2", 32'(busy), 32'd1);
    tick(); chk("s_busy_t3", 32'(busy), 32'd0);
    step();
    chk("s_char_held", 32'(anim_char), 32'h41);

    // 3. Burst A,B,C with dwell 1 (pop and push coincide on the third write)
    dwell = 4'd1;
    push(7'h41); push(7'h42); push(7'h43);
    chk("b_level_pushpop", 32'(level), 32'd2);
    expect_strobe("b_A", 7'h41);
    tick();
    expect_strobe("b_B", 7'h42);
    chk("b_level1", 32'(level), 32'd1);
    tick();
    expect_strobe("b_C", 7'h43);
    chk("b_level0", 32'(level), 32'd0);
    chk("b_busy_c", 32'(busy),  32'd1);
    tick();
    chk("b_busy_end", 32'(busy), 32'd0);

    // 4. Overflow with ena low, then drain the first DEPTH characters
    ena = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push(7'(7'h30 + i));
    chk("o_level",    32'(level),    32'(DEPTH));
    chk("o_ready",    32'(wr_ready), 32'd0);
    chk("o_overflow", 32'(overflow), 32'd1);
    chk("o_busy",     32'(busy),     32'd0);
    ena = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      expect_strobe("o_play", 7'(7'h30 + i));
      tick();
    end
    chk("o_level_drained", 32'(level),    32'd0);
    chk("o_busy_end",      32'(busy),     32'd0);
    chk("o_overflow_stk",  32'(overflow), 32'd1);

    // 5. dwell=0 acts as 1; ticks with ena low are ignored
    dwell = 4'd0;
    push(7'h5A);
    expect_strobe("d_Z", 7'h5A);
    step();
    ena = 1'b0;
    tick(); chk("d_frozen1", 32'(busy), 32'd1);
    tick(); chk("d_frozen2", 32'(busy), 32'd1);
    ena = 1'b1;
    step(); chk("d_wait", 32'(busy), 32'd1);
    tick(); chk("d_done", 32'(busy), 32'd0);

    // 6. Repeated character, with and without blank gap
    dwell = 4'd1;
    push(7'h41); push(7'h41);
    expect_strobe("g_A1", 7'h41);
    tick();
`ifdef SEG_SCHED_GAP_EN
    chk("g_blank1_strb", 32'(anim_strobe), 32'd1);
    chk("g_blank1_char", 32'(anim_char),   32'h00);
    tick(); chk("g_blank1_t1", 32'(busy), 32'd1);
    tick(); chk("g_blank1_t2", 32'(busy), 32'd0);
    expect_strobe("g_A2", 7'h41);
    tick();
    chk("g_blank2_strb", 32'(anim_strobe), 32'd1);
    chk("g_blank2_char", 32'(anim_char),   32'h00);
    tick(); chk("g_blank2_t1", 32'(busy), 32'd1);
    tick(); chk("g_blank2_t2", 32'(busy), 32'd0);
`else
    chk("g_noblank", 32'(anim_strobe), 32'd0);
    expect_strobe("g_A2", 7'h41);
    tick();
    chk("g_end_busy", 32'(busy), 32'd0);
    chk("g_end_char", 32'(anim_char), 32'h41);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
